// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl
//   Program-counter stage of the single-cycle CPU. Takes the ALU's taken flag
//   and a pre-scaled offset, produces the next fetch address, and owns the
//   run / single-step / halt control that gates the datapath through cpu_en.
//   Also keeps a retired-instruction count for the debug display.
//
// Parameters
//   PC_RESET      PC loaded on reset (text-segment base)
//   PC_INC        sequential increment in bytes
//
// Ports
//   clk           system clock, all state changes on the rising edge
//   rst_n         synchronous active-low reset
//   run_mode      1 = free run, 0 = single-step
//   step_btn      raw asynchronous step button level (active high)
//   halt_req      halt request, only looked at while cpu_en=1
//   alu_zero      branch/jal taken flag, valid in the same cycle
//   imm_off       sign-extended byte offset for a taken branch/jal
//   pc            current fetch address
//   pc_plus4      pc + PC_INC (jal link value), combinational
//   cpu_en        datapath commit enable (state is RUN or STEP)
//   state         00 IDLE, 01 RUN, 10 STEP, 11 HALT
//   misalign_err  sticky flag: a taken target was not word aligned
//   retire_cnt    number of committed instructions (wraps)
// -----------------------------------------------------------------------------
module pc_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned PC_INC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_mode,
    input  logic        step_btn,
    input  logic        halt_req,
    input  logic        alu_zero,
    input  logic [31:0] imm_off,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic        misalign_err,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_t;

    localparam logic [31:0] PC_INC_W = 32'(PC_INC);
    localparam int          SYNC_LEN = 3;   // two synchroniser flops + one edge-history flop

    state_t        state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [31:0]   retire_reg, retire_next;
    logic          misalign_reg, misalign_next;
    logic [SYNC_LEN-1:0] sync_reg;

    logic          step_pulse;
    logic [31:0]   seq_pc;
    logic [31:0]   target;
    logic          misalign;
    logic          commit;
    logic          halt_cond;

    // Step button chain: sync_reg[0..1] resynchronise the raw level, sync_reg[2]
    // remembers the previous synchronised level so a held button gives one pulse.
    generate
        for (genvar gi = 0; gi < SYNC_LEN; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= step_btn;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign step_pulse = sync_reg[1] & ~sync_reg[2];

    assign cpu_en    = (state_reg == RUN) || (state_reg == STEP);
    assign seq_pc    = pc_reg + PC_INC_W;
    assign target    = alu_zero ? (pc_reg + imm_off) : seq_pc;
    // Only a taken target can be misaligned; the sequential path stays aligned.
    assign misalign  = cpu_en & alu_zero & (target[1:0] != 2'b00);
    assign commit    = cpu_en & ~misalign;
    assign halt_cond = cpu_en & (halt_req | misalign);

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        retire_next   = retire_reg;
        misalign_next = misalign_reg;

        if (commit) begin
            pc_next     = target;
            retire_next = retire_reg + 32'd1;
        end
        if (misalign) begin
            misalign_next = 1'b1;
        end

        unique case (state_reg)
            IDLE: begin
                // run_mode has priority so a coincident press adds no extra STEP.
                if (run_mode)        state_next = RUN;
                else if (step_pulse) state_next = STEP;
            end
            RUN: begin
                if (halt_cond)       state_next = HALT;
                else if (!run_mode)  state_next = IDLE;
            end
            STEP: begin
                state_next = halt_cond ? HALT : IDLE;
            end
            HALT: begin
                state_next = HALT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= run_mode ? RUN : IDLE;
            pc_reg       <= PC_RESET;
            retire_reg   <= 32'd0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            retire_reg   <= retire_next;
            misalign_reg <= misalign_next;
        end
    end

    assign pc           = pc_reg;
    assign pc_plus4     = seq_pc;
    assign state        = state_reg;
    assign misalign_err = misalign_reg;
    assign retire_cnt   = retire_reg;

endmodule
